// File: rtl/memarb_pkg.sv
// ---------------------------------------------------------------------------
// memarb_pkg
// Shared encodings for the instruction/data memory port arbiter.
//   state_t      : arbiter FSM states (idle, memory access in flight, ack cycle)
//   owner_t      : which requester owns the access in flight
//   STARVE_CNT_W : width of the optional IF starvation guard counter
// ---------------------------------------------------------------------------
package memarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int STARVE_CNT_W = 3;

endpackage

// File: rtl/memarb_starve_ctr.sv
// ---------------------------------------------------------------------------
// memarb_starve_ctr
// Counts data grants issued while the instruction-fetch port is waiting and
// raises force_if once the count reaches STARVE_LIMIT, so the next grant
// goes to IF. Only instantiated when MEMARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   if_req_i  : IF request level
//   d_grant_i : a data grant is being made this cycle
//   if_grant_i: an IF grant is being made this cycle
//   force_if_o: next grant must go to IF
// ---------------------------------------------------------------------------
module memarb_starve_ctr
    import memarb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic d_grant_i,
    input  logic if_grant_i,
    output logic force_if_o
);

    logic [STARVE_CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (if_grant_i || !if_req_i) begin
            // IF got served or stopped asking: the starvation window restarts
            cnt_reg <= '0;
        end else if (d_grant_i) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign force_if_o = if_req_i && (cnt_reg == STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, variable-latency word memory between the CPU's
// instruction-fetch port and its data port. Accesses are serialised through
// an IDLE -> ACCESS -> DONE FSM; the owner's ack pulses for one cycle in DONE.
// Data requests win over IF requests. Defining MEMARB_STARVE_GUARD_EN adds a
// guard that forces an IF grant after STARVE_LIMIT back-to-back data grants.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   if_req_i/if_addr_i           : IF read request (held until if_ack_o)
//   if_ack_o/if_rdata_o          : IF completion pulse and fetched word
//   d_req_i/d_we_i/d_addr_i/
//   d_wdata_i                    : data request (held until d_ack_o)
//   d_ack_o/d_rdata_o            : data completion pulse and loaded word
//   mem_req_o/mem_we_o/
//   mem_addr_o/mem_wdata_o       : memory request, held until mem_ack_i
//   mem_ack_i/mem_rdata_i        : memory completion, read data same cycle
//   stall_o                      : any request still waiting for its ack
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    // Byte-offset bits are dropped on the way to the word memory
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t              state_reg, state_next;
    owner_t              owner_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                we_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;
    logic                grant_d;
    logic                grant_if;

`ifdef MEMARB_STARVE_GUARD_EN
    logic force_if;

    memarb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .d_grant_i  (grant_d),
        .if_grant_i (grant_if),
        .force_if_o (force_if)
    );

    assign grant_if = (state_reg == ST_IDLE) && if_req_i && (force_if || !d_req_i);
    assign grant_d  = (state_reg == ST_IDLE) && d_req_i && !grant_if;
`else
    assign grant_d  = (state_reg == ST_IDLE) && d_req_i;
    assign grant_if = (state_reg == ST_IDLE) && if_req_i && !d_req_i;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (grant_d || grant_if) state_next = ST_ACCESS;
            ST_ACCESS: if (mem_ack_i)           state_next = ST_DONE;
            ST_DONE:                            state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured only at grant so the requester may change
    // or drop them while the access is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_reg    <= OWN_NONE;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            if (grant_d) begin
                owner_reg <= OWN_D;
                addr_reg  <= d_addr_i;
                we_reg    <= d_we_i;
                wdata_reg <= d_wdata_i;
            end else if (grant_if) begin
                owner_reg <= OWN_IF;
                addr_reg  <= if_addr_i;
                we_reg    <= 1'b0;
                wdata_reg <= '0;
            end
            if (state_reg == ST_ACCESS && mem_ack_i) begin
                if (owner_reg == OWN_D) begin
                    d_rdata_reg <= mem_rdata_i;
                end else if (owner_reg == OWN_IF) begin
                    if_rdata_reg <= mem_rdata_i;
                end
            end
            if (state_reg == ST_DONE) begin
                owner_reg <= OWN_NONE;
                we_reg    <= 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        if_ack_o  = 1'b0;
        d_ack_o   = 1'b0;
        case (state_reg)
            ST_ACCESS: begin
                mem_req_o = 1'b1;
                mem_we_o  = we_reg;
            end
            ST_DONE: begin
                if_ack_o = (owner_reg == OWN_IF);
                d_ack_o  = (owner_reg == OWN_D);
            end
            default: ;
        endcase
    end

    assign mem_addr_o  = addr_reg & WORD_MASK;
    assign mem_wdata_o = wdata_reg;
    assign if_rdata_o  = if_rdata_reg;
    assign d_rdata_o   = d_rdata_reg;
    assign stall_o     = (if_req_i && !if_ack_o) || (d_req_i && !d_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus against mem_port_arbiter with a small variable-latency
// memory model. Expected acks are queued when requests are issued; a monitor
// on the falling edge pops and compares each ack as it appears.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              stall_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_ack_o     (d_ack_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o)
    );

    // ---------------- memory model ----------------
    int          mem_delay = 1;   // ack on the (mem_delay+1)-th ACCESS cycle
    logic        hold_ack  = 1'b0;
    int          acc_cnt   = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    int          wr_count  = 0;

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0001_0008: return 32'h0050_0093;
            32'h0000_2000: return 32'h1111_1111;
            32'h0000_3004: return 32'h2222_2222;
            32'h0000_5000: return 32'h5555_5555;
            32'h0000_6000: return 32'h6666_6666;
            32'h0000_7000: return 32'h7777_7777;
            default:       return {16'hBAD0, a[15:0]};
        endcase
    endfunction

    assign mem_rdata_i = mem_lookup(mem_addr_o);
    assign mem_ack_i   = mem_req_o && !hold_ack && (acc_cnt == mem_delay);

    always @(posedge clk) begin
        if (mem_req_o && !mem_ack_i) acc_cnt <= acc_cnt + 1;
        else                         acc_cnt <= 0;
        if (mem_req_o && mem_ack_i && mem_we_o) begin
            last_waddr <= mem_addr_o;
            last_wdata <= mem_wdata_o;
            wr_count   <= wr_count + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   if_acks = 0;
    int   d_acks  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic chk, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.chk  = chk;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic is_d, input logic [31:0] data);
        exp_t e;
        checks++;
        if (is_d) d_acks++; else if_acks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_ack port=%s actual=0x%08h required=no_ack",
                     is_d ? "D" : "IF", data);
        end else begin
            e = exp_q.pop_front();
            if (e.is_d != is_d) begin
                errors++;
                $display("FAIL sb_owner actual=%s required=%s",
                         is_d ? "D" : "IF", e.is_d ? "D" : "IF");
            end else if (e.chk && data !== e.data) begin
                errors++;
                $display("FAIL sb_rdata port=%s actual=0x%08h required=0x%08h",
                         is_d ? "D" : "IF", data, e.data);
            end else begin
                $display("ack port=%s rdata=0x%08h t=%0t", is_d ? "D" : "IF", data, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i && (if_ack_o || d_ack_o)) begin
            checks++;
            if (if_ack_o && d_ack_o) begin
                errors++;
                $display("FAIL dual_ack actual=both required=one");
            end
            if (if_ack_o) sb_pop(1'b0, if_rdata_o);
            if (d_ack_o)  sb_pop(1'b1, d_rdata_o);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles until the selected ack, or -1 on timeout
    task automatic wait_ack(input logic is_d, input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (is_d ? d_ack_o : if_ack_o) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        int n;
        int base;

        rst_i     = 1'b1;
        if_req_i  = 1'b0;
        if_addr_i = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        repeat (3) tick();

        // Reset state
        check("rst_mem_req",  {31'd0, mem_req_o}, 32'd0);
        check("rst_mem_we",   {31'd0, mem_we_o},  32'd0);
        check("rst_acks",     {30'd0, if_ack_o, d_ack_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_if_rdata", if_rdata_o, 32'd0);
        check("rst_d_rdata",  d_rdata_o,  32'd0);
        rst_i = 1'b0;
        tick();

        // T1: IF only, memory acks one cycle after the request rises
        mem_delay = 1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0001_0008;
        push_exp(1'b0, 1'b1, 32'h0050_0093);
        tick();
        check("t1_mem_addr", mem_addr_o, 32'h0001_0008);
        check("t1_mem_we",   {31'd0, mem_we_o}, 32'd0);
        wait_ack(1'b0, 20, k);
        check("t1_latency", k, 2);   // one cycle already consumed above
        if_req_i = 1'b0;
        tick();

        // T2: data write, unaligned address, memory acks after 3 cycles
        mem_delay = 3;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h0000_1003;
        d_wdata_i = 32'hDEAD_BEEF;
        push_exp(1'b1, 1'b0, 32'h0);
        #1;
        check("t2_stall_c0", {31'd0, stall_o}, 32'd1);
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (d_ack_o) begin
                k = i;
                break;
            end
            if (i == 1) begin
                check("t2_mem_addr", mem_addr_o, 32'h0000_1000);
                check("t2_mem_we",   {31'd0, mem_we_o}, 32'd1);
            end
            check("t2_stall", {31'd0, stall_o}, 32'd1);
        end
        check("t2_ack_cycle", k, 5);
        check("t2_stall_at_ack", {31'd0, stall_o}, 32'd0);
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        tick();
        check("t2_waddr", last_waddr, 32'h0000_1000);
        check("t2_wdata", last_wdata, 32'hDEAD_BEEF);

        // T3: IF and D in the same cycle: D first, then IF
        mem_delay = 1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_2000;
        d_req_i   = 1'b1;
        d_addr_i  = 32'h0000_3004;
        push_exp(1'b1, 1'b1, 32'h2222_2222);
        push_exp(1'b0, 1'b1, 32'h1111_1111);
        wait_ack(1'b1, 20, k);
        check("t3_d_latency", k, 3);
        check("t3_if_rdata_held", if_rdata_o, 32'h0050_0093);
        d_req_i = 1'b0;
        wait_ack(1'b0, 20, k2);
        check("t3_if_gap", k2, 4);
        check("t3_d_rdata_held", d_rdata_o, 32'h2222_2222);
        if_req_i = 1'b0;
        tick();

        // T6: D drops its request mid-access; the access still completes
        mem_delay = 3;
        base      = d_acks;
        d_req_i   = 1'b1;
        d_addr_i  = 32'h0000_5000;
        push_exp(1'b1, 1'b1, 32'h5555_5555);
        tick();
        tick();
        d_req_i  = 1'b0;
        d_addr_i = 32'h0000_0BAD;
        wait_ack(1'b1, 20, k);
        check("t6_latency", k, 3);
        check("t6_mem_req_after_ack", {31'd0, mem_req_o}, 32'd0);
        repeat (4) tick();
        check("t6_single_ack", d_acks, base + 1);

        // T4: reset while the memory withholds its ack
        hold_ack = 1'b1;
        d_req_i  = 1'b1;
        d_addr_i = 32'h0000_4000;
        tick();
        tick();
        check("t4_mem_req_pending", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        check("t4_mem_req_dropped", {31'd0, mem_req_o}, 32'd0);
        check("t4_no_ack", {30'd0, if_ack_o, d_ack_o}, 32'd0);
        check("t4_if_rdata_cleared", if_rdata_o, 32'd0);
        rst_i    = 1'b0;
        d_req_i  = 1'b0;
        hold_ack = 1'b0;
        repeat (4) tick();
        mem_delay = 1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0001_0008;
        push_exp(1'b0, 1'b1, 32'h0050_0093);
        wait_ack(1'b0, 20, k);
        check("t4_fresh_if_latency", k, 3);
        if_req_i = 1'b0;
        tick();

        // T5: data request held continuously while IF waits
        mem_delay = 0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_7000;
        d_req_i   = 1'b1;
        d_addr_i  = 32'h0000_6000;
`ifdef MEMARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b1, 32'h6666_6666);
        push_exp(1'b0, 1'b1, 32'h7777_7777);
        n = 0;
        k = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (d_ack_o) n++;
            if (if_ack_o) begin
                k = i;
                break;
            end
        end
        check("t5_if_granted", {31'd0, k > 0}, 32'd1);
        check("t5_d_grants_before_if", n, 4);
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        tick();
`else
        for (int i = 0; i < 20; i++) push_exp(1'b1, 1'b1, 32'h6666_6666);
        base = if_acks;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (d_ack_o) n++;
            if (n == 20) break;
        end
        check("t5_d_accesses", n, 20);
        check("t5_if_starved", if_acks, base);
        push_exp(1'b0, 1'b1, 32'h7777_7777);
        d_req_i = 1'b0;
        wait_ack(1'b0, 20, k);
        check("t5_if_after_release", {31'd0, k > 0}, 32'd1);
        if_req_i = 1'b0;
        tick();
`endif

        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
